// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared state encoding and helpers for pulse_burst_gen
package pulse_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HIGH = ST_HIGH,
    S_GAP  = ST_GAP
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a down-counter that must hold values up to n-1, never zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down counter of queued burst requests
module sat_counter
  import pulse_pkg::*;
#(
  parameter int MAX = 3,
  parameter int PW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] count,
  output logic          drop
);

  logic full;

  assign full = (count == PW'(MAX));
  // A lone increment into a full queue is the only way a request gets lost.
  assign drop = inc && !dec && full;

  // Count register: simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + PW'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - PW'(1);
    end
  end

endmodule

// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - stretches request pulses into fixed-width bursts with guaranteed gaps
module pulse_burst_gen
  import pulse_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int GAP      = 2,
  parameter int MAX_PEND = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         p_in,
  output logic                         q,
  output logic                         busy,
  output logic [$clog2(MAX_PEND+1)-1:0] pend,
  output logic                         ovf
);

  localparam int CW = cnt_width(max_int(WIDTH, GAP));

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          q_n;
  logic          inc, dec, drop;

  sat_counter #(
    .MAX (MAX_PEND)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .count (pend),
    .drop  (drop)
  );

  // State, burst counter, output level and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      q     <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      if (drop) ovf <= 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

  // Next-state, next-output and queue accounting for each edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state)
      S_IDLE: begin
        if (p_in) begin
          state_n = S_HIGH;
          cnt_n   = CW'(WIDTH - 1);
          q_n     = 1'b1;
        end
      end
      S_HIGH: begin
        inc = p_in;
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          state_n = S_GAP;
          cnt_n   = CW'(GAP - 1);
          q_n     = 1'b0;
        end
      end
      S_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
          inc   = p_in;
        end else if ((pend != '0) || p_in) begin
          // A fresh request at the exit edge is either consumed directly
          // (empty queue) or swapped for the oldest queued one.
          state_n = S_HIGH;
          cnt_n   = CW'(WIDTH - 1);
          q_n     = 1'b1;
          dec     = (pend != '0) && !p_in;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        q_n     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb/tb_pulse_burst_gen.sv - directed self-checking bench for pulse_burst_gen
module tb_pulse_burst_gen;

  logic       clk;
  logic       rst;
  logic       p_in;
  logic       q;
  logic       busy;
  logic [1:0] pend;
  logic       ovf;

  int total;
  int bad;
  int edge_i;

  pulse_burst_gen #(
    .WIDTH    (3),
    .GAP      (2),
    .MAX_PEND (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .p_in (p_in),
    .q    (q),
    .busy (busy),
    .pend (pend),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  // Drive one edge worth of inputs, then check all outputs 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic p,
                      input logic eq, input logic eb, input int ep, input logic eo);
    rst  = r;
    p_in = p;
    @(posedge clk);
    #1;
    chk({tag, ".q"},    edge_i, 32'(q),    32'(eq));
    chk({tag, ".busy"}, edge_i, 32'(busy), 32'(eb));
    chk({tag, ".pend"}, edge_i, 32'(pend), 32'(ep));
    chk({tag, ".ovf"},  edge_i, 32'(ovf),  32'(eo));
    edge_i++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    p_in  = 1'b1;

    // Reset held two cycles with p_in high, then idle: no burst may follow.
    edge_i = 0;
    step("rst", 1, 1, 0, 0, 0, 0);
    step("rst", 1, 1, 0, 0, 0, 0);
    step("rst_idle", 0, 0, 0, 0, 0, 0);
    step("rst_idle", 0, 0, 0, 0, 0, 0);

    // Single pulse at edge 0.
    edge_i = 0;
    step("single", 0, 1, 1, 1, 0, 0);
    step("single", 0, 0, 1, 1, 0, 0);
    step("single", 0, 0, 1, 1, 0, 0);
    step("single", 0, 0, 0, 1, 0, 0);
    step("single", 0, 0, 0, 1, 0, 0);
    step("single", 0, 0, 0, 0, 0, 0);
    step("single", 0, 0, 0, 0, 0, 0);

    // Pulses at edges 0,1,2: three bursts starting after edges 0, 5, 10.
    edge_i = 0;
    step("three", 0, 1, 1, 1, 0, 0);
    step("three", 0, 1, 1, 1, 1, 0);
    step("three", 0, 1, 1, 1, 2, 0);
    step("three", 0, 0, 0, 1, 2, 0);
    step("three", 0, 0, 0, 1, 2, 0);
    step("three", 0, 0, 1, 1, 1, 0);
    step("three", 0, 0, 1, 1, 1, 0);
    step("three", 0, 0, 1, 1, 1, 0);
    step("three", 0, 0, 0, 1, 1, 0);
    step("three", 0, 0, 0, 1, 1, 0);
    step("three", 0, 0, 1, 1, 0, 0);
    step("three", 0, 0, 1, 1, 0, 0);
    step("three", 0, 0, 1, 1, 0, 0);
    step("three", 0, 0, 0, 1, 0, 0);
    step("three", 0, 0, 0, 1, 0, 0);
    step("three", 0, 0, 0, 0, 0, 0);
    step("three", 0, 0, 0, 0, 0, 0);

    // Pulses at edges 0..4: queue saturates at 3, fifth request dropped, four bursts.
    edge_i = 0;
    step("sat", 0, 1, 1, 1, 0, 0);
    step("sat", 0, 1, 1, 1, 1, 0);
    step("sat", 0, 1, 1, 1, 2, 0);
    step("sat", 0, 1, 0, 1, 3, 0);
    step("sat", 0, 1, 0, 1, 3, 1);
    step("sat", 0, 0, 1, 1, 2, 1);
    step("sat", 0, 0, 1, 1, 2, 1);
    step("sat", 0, 0, 1, 1, 2, 1);
    step("sat", 0, 0, 0, 1, 2, 1);
    step("sat", 0, 0, 0, 1, 2, 1);
    step("sat", 0, 0, 1, 1, 1, 1);
    step("sat", 0, 0, 1, 1, 1, 1);
    step("sat", 0, 0, 1, 1, 1, 1);
    step("sat", 0, 0, 0, 1, 1, 1);
    step("sat", 0, 0, 0, 1, 1, 1);
    step("sat", 0, 0, 1, 1, 0, 1);
    step("sat", 0, 0, 1, 1, 0, 1);
    step("sat", 0, 0, 1, 1, 0, 1);
    step("sat", 0, 0, 0, 1, 0, 1);
    step("sat", 0, 0, 0, 1, 0, 1);
    step("sat", 0, 0, 0, 0, 0, 1);
    step("sat", 0, 0, 0, 0, 0, 1);

    // Only reset clears the sticky overflow flag.
    edge_i = 0;
    step("ovf_clr", 1, 0, 0, 0, 0, 0);

    // Pulse at edge 0 and again exactly at the gap exit edge 5.
    edge_i = 0;
    step("gapexit", 0, 1, 1, 1, 0, 0);
    step("gapexit", 0, 0, 1, 1, 0, 0);
    step("gapexit", 0, 0, 1, 1, 0, 0);
    step("gapexit", 0, 0, 0, 1, 0, 0);
    step("gapexit", 0, 0, 0, 1, 0, 0);
    step("gapexit", 0, 1, 1, 1, 0, 0);
    step("gapexit", 0, 0, 1, 1, 0, 0);
    step("gapexit", 0, 0, 1, 1, 0, 0);
    step("gapexit", 0, 0, 0, 1, 0, 0);
    step("gapexit", 0, 0, 0, 1, 0, 0);
    step("gapexit", 0, 0, 0, 0, 0, 0);

    // Pulses at edges 0,1,2 then reset at edge 3 (with p_in high): burst aborted, queue flushed.
    edge_i = 0;
    step("abort", 0, 1, 1, 1, 0, 0);
    step("abort", 0, 1, 1, 1, 1, 0);
    step("abort", 0, 1, 1, 1, 2, 0);
    step("abort", 1, 1, 0, 0, 0, 0);
    step("abort", 0, 0, 0, 0, 0, 0);
    step("abort", 0, 0, 0, 0, 0, 0);
    step("abort", 0, 0, 0, 0, 0, 0);
    step("abort", 0, 0, 0, 0, 0, 0);
    step("abort", 0, 0, 0, 0, 0, 0);
    step("abort", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Level-output pulse generator: the transmit-side counterpart of the team's edge-to-pulse synchronizer. It consumes single-cycle request pulses already synchronous to `clk` and turns each one into a fixed-width high level on `q`. Each high level is followed by a guaranteed low gap. Requests that arrive while a burst is in progress are queued in a saturating counter and replayed in order. The block drives slow consumers (LEDs, buzzers, strobe-sensitive peripherals) that cannot see one-cycle pulses.

## Interface
- `WIDTH`, 3: high-time of each burst in `clk` cycles; legal range ≥ 1.
- `GAP`, 2: minimum low-time after each burst in `clk` cycles; legal range ≥ 1.
- `MAX_PEND`, 3: maximum number of queued requests; legal range ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p_in`  in  1  request pulse, sampled every rising edge; each high sample is one request.
- `q`  out  1  registered burst output.
- `busy`  out  1  high whenever state ≠ IDLE.
- `pend`  out  $clog2(MAX_PEND+1)  number of queued requests.
- `ovf`  out  1  sticky flag: a request was dropped; cleared only by `rst`.

## Operation
- FSM states: IDLE, HIGH, GAP. Down-counter `cnt` is sized $clog2(max(WIDTH,GAP)).
- IDLE, `p_in`=1: go to HIGH, `cnt`←WIDTH-1, `q`←1.
- HIGH, `cnt`≠0: decrement `cnt`.
- HIGH, `cnt`=0: go to GAP, `cnt`←GAP-1, `q`←0.
- GAP, `cnt`≠0: decrement `cnt`.
- GAP, `cnt`=0 (exit edge):
  - if `pend`>0 or `p_in`=1: go to HIGH, `cnt`←WIDTH-1, `q`←1.
  - otherwise: go to IDLE.
- Queue accounting:
  - `p_in`=1 in HIGH, or in GAP on a non-exit edge: `pend`+1.
  - GAP exit with `p_in`=1 and `pend`=0: the request is consumed directly; `pend` unchanged.
  - GAP exit with `pend`>0 and `p_in`=0: `pend`−1.
  - GAP exit with `pend`>0 and `p_in`=1: one request is consumed and one queued; `pend` unchanged.
- Saturation: a request that would push `pend` past MAX_PEND is dropped, and `ovf`←1 on the same edge.
- Queued requests are never lost except on saturation or reset.

## Timing
- Reset values: `q`=0, `busy`=0, `pend`=0, `ovf`=0, state=IDLE, `cnt`=0.
- `rst` overrides everything, including `p_in` sampled on the same edge.
- Reset mid-burst aborts immediately: `q` is low the cycle after the reset edge, and the queue is flushed.
- Latency: `p_in` high at edge k in IDLE gives `q`=1 after edge k.
- `q` stays high for exactly WIDTH cycles, then is low for at least GAP cycles.
- Back-to-back bursts repeat with period WIDTH+GAP.
- `busy` rises together with `q` and falls after the GAP exit edge when no request is pending.
- `q`, `busy`, `pend` and `ovf` are all registered; there is no combinational path from `p_in` to any output.

## Structure
- Shared package `pulse_pkg` holds the state encoding localparams: IDLE=2'd0, HIGH=2'd1, GAP=2'd2.
- Sub-module `sat_counter` implements `pend`:
  - inputs: `inc`, `dec`, `clk`, `rst`;
  - saturates at MAX_PEND and asserts a `drop` output;
  - `inc` and `dec` together leave the count unchanged.
- Top level holds the FSM, `cnt`, and the `q`/`ovf` registers.

## Test plan
All scenarios use WIDTH=3, GAP=2, MAX_PEND=3.
- Reset: hold `rst` 2 cycles with `p_in`=1 → `q`=0, `busy`=0, `pend`=0, `ovf`=0; no burst follows.
- Single pulse at edge 0 → `q`=1 after edges 0–2, `q`=0 after edge 3; `busy` falls after edge 5; `pend` stays 0.
- Pulses at edges 0, 1, 2 → `pend` reads 1 then 2; `q` rises after edges 0, 5, 10; three bursts total; `pend`=0 after edge 10.
- Pulses at edges 0–4 → `pend` saturates at 3; the 5th request is dropped and `ovf`=1 after edge 4; exactly four bursts; `ovf` remains 1.
- Single pulse at edge 0, second pulse at edge 5 (GAP exit) → `q` rises again after edge 5 (low for exactly 2 cycles); `pend` stays 0.
- Pulses at edges 0, 1, 2, then `rst` at edge 3 → `q`=0, `busy`=0, `pend`=0, `ovf`=0 after edge 3; no further bursts.
